// File: rtl/sdram_test_pkg.sv
// Shared types and helpers for the SDRAM write/read-back test sequencer.
// Holds the run states and the address-derived data pattern.
package sdram_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [1:0] BE_ALL = 2'b11;

    // Callers zero-extend the word address to 32 bits, so the upper half
    // holds only the address bits above bit 15.
    function automatic logic [15:0] pat(
        input logic [31:0] a,
        input logic [15:0] s
    );
        return a[15:0] ^ a[31:16] ^ s;
    endfunction

endpackage

// File: rtl/sdram_test_if.sv
// Avalon-MM bus between the test sequencer (master) and the SDRAM
// controller slave port.
interface sdram_test_if #(
    parameter int ADDR_W = 25
) ();

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [15:0]       avm_writedata;
    logic [1:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [15:0]       avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );

endinterface

// File: rtl/sdram_test_checker.sv
// Read-back checker: walks the compare address, counts mismatches with
// saturation and captures the first failing address of a run.
module sdram_test_checker
    import sdram_test_pkg::*;
#(
    parameter int ADDR_W = 25
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rdv,
    input  logic [15:0]       i_rdata,
    input  logic              i_clear,
    input  logic [15:0]       i_seed,
    output logic [15:0]       o_err_count,
    output logic [ADDR_W-1:0] o_first_err_addr
);

    logic [ADDR_W-1:0] r_caddr;
    logic [15:0]       r_err_count;
    logic [ADDR_W-1:0] r_first_err_addr;
    logic              r_seen;

    logic [15:0] w_expect;
    logic        w_miss;

    assign w_expect = pat(32'(r_caddr), i_seed);
    assign w_miss   = i_rdv && (i_rdata != w_expect);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_caddr          <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_seen           <= 1'b0;
        end else if (i_clear) begin
            r_caddr          <= '0;
            r_err_count      <= '0;
            r_first_err_addr <= '0;
            r_seen           <= 1'b0;
        end else begin
            if (i_rdv) begin
                r_caddr <= r_caddr + 1'b1;
            end
            if (w_miss) begin
                if (r_err_count != 16'hFFFF) begin
                    r_err_count <= r_err_count + 16'd1;
                end
                if (!r_seen) begin
                    r_seen           <= 1'b1;
                    r_first_err_addr <= r_caddr;
                end
            end
        end
    end

    assign o_err_count      = r_err_count;
    assign o_first_err_addr = r_first_err_addr;

endmodule

// File: rtl/sdram_test_sequencer.sv
// SDRAM test sequencer: writes a seeded pattern over 0..LAST_ADDR, then
// reads it back with pipelined reads and reports pass/fail status.
module sdram_test_sequencer
    import sdram_test_pkg::*;
#(
    parameter int              ADDR_W    = 25,
    parameter int              DATA_W    = 16,
    parameter longint unsigned LAST_ADDR = 2**25-1,
    parameter int              MAX_PEND  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       seed,
    sdram_test_if.master      bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int                PW   = $clog2(MAX_PEND) + 1;
    localparam logic [PW-1:0]     PMAX = PW'(MAX_PEND);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

    if (ADDR_W < 17 || ADDR_W > 32) begin : g_bad_aw
        $error("ADDR_W must be within 17..32");
    end
    if (DATA_W != 16) begin : g_bad_dw
        $error("DATA_W must be 16");
    end
    if (MAX_PEND < 2 || MAX_PEND > 64 ||
        (MAX_PEND & (MAX_PEND - 1)) != 0) begin : g_bad_mp
        $error("MAX_PEND must be a power of 2 within 2..64");
    end
    if ((LAST_ADDR >> ADDR_W) != 0) begin : g_bad_last
        $error("LAST_ADDR does not fit in ADDR_W bits");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_raddr;
    logic [PW-1:0]     r_pend;
    logic [PW-1:0]     w_pend_nxt;
    logic [15:0]       r_seed;
    logic              r_busy;
    logic              r_done;

    logic w_go;
    logic w_wr_en;
    logic w_rd_en;
    logic w_wacc;
    logic w_racc;
    logic w_rdv;
    logic w_wlast;
    logic w_rlast;
    logic w_fin;

    assign w_go    = start && (r_state == IDLE || r_state == DONE);
    assign w_wr_en = (r_state == WRITE);
    assign w_rd_en = (r_state == READ) && (r_pend < PMAX);
    assign w_wacc  = w_wr_en && !bus.avm_waitrequest;
    assign w_racc  = w_rd_en && !bus.avm_waitrequest;
    assign w_wlast = w_wacc && (r_waddr == LAST);
    assign w_rlast = w_racc && (r_raddr == LAST);
    assign w_rdv   = bus.avm_readdatavalid &&
                     (r_state == READ || r_state == DRAIN);
    assign w_fin   = (r_state == DRAIN) && (w_pend_nxt == '0);

    // A read accept and a returning word in the same cycle cancel out.
    always_comb begin
        w_pend_nxt = r_pend;
        unique case ({w_racc, w_rdv})
            2'b10:   w_pend_nxt = r_pend + PW'(1);
            2'b01:   w_pend_nxt = r_pend - PW'(1);
            default: w_pend_nxt = r_pend;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start)   w_state_nxt = WRITE;
            DONE:    if (start)   w_state_nxt = WRITE;
            WRITE:   if (w_wlast) w_state_nxt = READ;
            READ:    if (w_rlast) w_state_nxt = DRAIN;
            DRAIN:   if (w_fin)   w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_waddr <= '0;
            r_raddr <= '0;
            r_pend  <= '0;
            r_seed  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
            if (w_go) begin
                r_seed  <= seed;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
                r_waddr <= '0;
            end
            // Counters stop at LAST so a full-range test never wraps.
            if (w_wacc && !w_wlast) begin
                r_waddr <= r_waddr + 1'b1;
            end
            if (w_wlast) begin
                r_raddr <= '0;
            end
            if (w_racc && !w_rlast) begin
                r_raddr <= r_raddr + 1'b1;
            end
            if (w_fin) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.avm_address = '0;
        if (r_state == WRITE) begin
            bus.avm_address = r_waddr;
        end else if (r_state == READ) begin
            bus.avm_address = r_raddr;
        end
    end

    assign bus.avm_write      = w_wr_en;
    assign bus.avm_read       = w_rd_en;
    assign bus.avm_writedata  = w_wr_en ? pat(32'(r_waddr), r_seed) : '0;
    assign bus.avm_byteenable = BE_ALL;

    sdram_test_checker #(
        .ADDR_W (ADDR_W)
    ) u_chk (
        .clk              (clk),
        .reset            (reset),
        .i_rdv            (w_rdv),
        .i_rdata          (bus.avm_readdata),
        .i_clear          (w_go),
        .i_seed           (r_seed),
        .o_err_count      (err_count),
        .o_first_err_addr (first_err_addr)
    );

    assign busy = r_busy;
    assign done = r_done;
    assign pass = r_done && (err_count == 16'd0);

endmodule

// File: tb/tb_sdram_test_sequencer.sv
// Bench for sdram_test_sequencer: a randomized Avalon slave with a memory,
// read latency queue and a run-level reference model of the expected outcome.
module tb_sdram_test_sequencer;
    import sdram_test_pkg::*;

    localparam int AW = 25;
    localparam int LA = 15;
    localparam int MP = 4;
    localparam int NW = LA + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   seed = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;

    sdram_test_if #(.ADDR_W(AW)) bus ();

    sdram_test_sequencer #(
        .ADDR_W    (AW),
        .DATA_W    (16),
        .LAST_ADDR (LA),
        .MAX_PEND  (MP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .seed           (seed),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        int            due;
    } rd_t;

    rd_t           q[$];
    logic [15:0]   mem[NW];
    int            p = 0;
    int            lat = 2;
    int            wr_pct = 0;
    int            cmode = 0;
    logic [15:0]   mseed = '0;
    int            nw, nr, ndel, mp, peak;
    int            pend_err, proto_err, wdat_err, sc_seen;
    int            first_wr, last_rdv;
    logic [15:0]   e_err;
    logic [AW-1:0] e_first;
    bit            e_seen;
    bit            prev_stall = 1'b0;
    logic [AW+17:0] prev_sig = '0;

    int n_tests = 0;
    int n_fail = 0;

    function automatic logic [15:0] patm(input int a, input logic [15:0] s);
        return 16'(a % 65536) ^ 16'(a / 65536) ^ s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave: decisions are made on the falling edge for the next rising edge.
    always @(negedge clk) begin
        rd_t         it;
        logic [15:0] d;
        logic        rs, ws;
        int          mb;
        p = p + 1;
        if (reset) begin
            q.delete();
            mp = 0;
            bus.avm_waitrequest   = 1'b0;
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = '0;
            prev_stall = 1'b0;
        end else begin
            if (int'(dut.r_pend) != mp) pend_err++;
            mb = mp;
            if (q.size() > 0 && q[0].due <= p) begin
                it = q.pop_front();
                d = mem[it.a[3:0]];
                if (cmode == 1 && it.a == 5) d = d ^ 16'h0001;
                if (cmode == 2) d = ~d;
                if (d != patm(int'(it.a), mseed)) begin
                    if (!e_seen) begin
                        e_seen  = 1'b1;
                        e_first = it.a;
                    end
                    if (e_err != 16'hFFFF) e_err = e_err + 16'd1;
                end
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = d;
                ndel++;
                mp--;
                last_rdv = p;
            end else begin
                bus.avm_readdatavalid = 1'b0;
                bus.avm_readdata      = '0;
            end
            bus.avm_waitrequest = ($urandom_range(99) < wr_pct);
            rs = bus.avm_read;
            ws = bus.avm_write;
            if (rs && ws) proto_err++;
            if (bus.avm_byteenable != 2'b11) proto_err++;
            if (prev_stall &&
                {rs, ws, bus.avm_address, bus.avm_writedata} != prev_sig)
                proto_err++;
            if (ws && first_wr < 0) first_wr = p;
            if ((rs || ws) && !bus.avm_waitrequest) begin
                if (ws) begin
                    if (int'(bus.avm_address) != nw ||
                        bus.avm_writedata != patm(nw, mseed))
                        wdat_err++;
                    mem[bus.avm_address[3:0]] = bus.avm_writedata;
                    nw++;
                end else begin
                    if (int'(bus.avm_address) != nr) wdat_err++;
                    if (bus.avm_readdatavalid && mb == 3) sc_seen++;
                    q.push_back('{bus.avm_address, p + lat});
                    nr++;
                    mp++;
                    if (mp > peak) peak = mp;
                end
            end
            prev_stall = (rs || ws) && bus.avm_waitrequest;
            prev_sig   = {rs, ws, bus.avm_address, bus.avm_writedata};
        end
    end

    task automatic clear_model(input logic [15:0] sd, input int l,
                               input int w, input int m);
        lat = l; wr_pct = w; cmode = m; mseed = sd;
        nw = 0; nr = 0; ndel = 0; peak = 0;
        pend_err = 0; proto_err = 0; wdat_err = 0; sc_seen = 0;
        first_wr = -1; last_rdv = -1;
        e_err = '0; e_first = '0; e_seen = 1'b0;
    endtask

    // Called just after a rising edge; runs one complete test pass.
    task automatic run(input logic [15:0] sd, input int l, input int w,
                       input int m, input bit mid, input bit frc,
                       input bit want_full, input bit want_sc,
                       input string tg);
        int s;
        int dp;
        bit fd;
        clear_model(sd, l, w, m);
        dp = -1;
        fd = 1'b0;
        start = 1'b1;
        seed  = sd;
        s = p + 1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (done) begin
                dp = p;
                break;
            end
            start = 1'b0;
            if (mid && nw == 5 && !fd) begin
                fd = 1'b1;
                start = 1'b1;
                seed = ~sd;
            end
            if (frc && ndel == 4 && !fd) begin
                fd = 1'b1;
                force dut.u_chk.r_err_count = 16'hFFFD;
                release dut.u_chk.r_err_count;
                e_err = 16'hFFFD;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tg, ":done"}, 64'(done), 64'd1);
        chk({tg, ":busy"}, 64'(busy), 64'd0);
        chk({tg, ":nwrites"}, 64'(nw), 64'(NW));
        chk({tg, ":nreads"}, 64'(nr), 64'(NW));
        chk({tg, ":ndata"}, 64'(ndel), 64'(NW));
        chk({tg, ":wdata"}, 64'(wdat_err), 64'd0);
        chk({tg, ":protocol"}, 64'(proto_err), 64'd0);
        chk({tg, ":pend"}, 64'(pend_err), 64'd0);
        chk({tg, ":peak_le"}, 64'(peak <= MP), 64'd1);
        chk({tg, ":err_count"}, 64'(err_count), 64'(e_err));
        chk({tg, ":first_err"}, 64'(first_err_addr), 64'(e_first));
        chk({tg, ":pass"}, 64'(pass), 64'(e_err == 16'd0));
        chk({tg, ":wr_lat"}, 64'(first_wr), 64'(s + 1));
        chk({tg, ":done_lat"}, 64'(dp), 64'(last_rdv));
        if (want_full) chk({tg, ":peak"}, 64'(peak), 64'(MP));
        if (want_sc) chk({tg, ":samecyc"}, 64'(sc_seen > 0), 64'd1);
        if (mid) chk({tg, ":seed_kept"}, 64'(dut.r_seed), 64'(sd));
    endtask

    task automatic check_idle(input string tg);
        chk({tg, ":busy"}, 64'(busy), 64'd0);
        chk({tg, ":done"}, 64'(done), 64'd0);
        chk({tg, ":pass"}, 64'(pass), 64'd0);
        chk({tg, ":err"}, 64'(err_count), 64'd0);
        chk({tg, ":first"}, 64'(first_err_addr), 64'd0);
        chk({tg, ":cmd"}, 64'({bus.avm_read, bus.avm_write}), 64'd0);
        chk({tg, ":addr"}, 64'(bus.avm_address), 64'd0);
        chk({tg, ":wdata"}, 64'(bus.avm_writedata), 64'd0);
        chk({tg, ":be"}, 64'(bus.avm_byteenable), 64'd3);
        chk({tg, ":state"}, 64'(dut.r_state), 64'(IDLE));
    endtask

    initial begin
        bit hit;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        run(16'hA5A5, 2, 0, 0, 0, 0, 0, 0, "clean");
        run(16'hA5A5, 2, 0, 1, 0, 0, 0, 0, "flip5");
        run(16'($urandom), 6, 50, 0, 0, 0, 0, 0, "rand");
        run(16'hA5A5, 3, 0, 0, 1, 0, 0, 1, "samecyc");

        clear_model(16'h1234, 6, 0, 0);
        hit = 1'b0;
        start = 1'b1;
        seed  = 16'h1234;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (dut.r_state == READ && dut.r_pend == 2) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("midrst:reached", 64'(hit), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_idle("midrst");
        reset = 1'b0;
        @(posedge clk); #1;
        run(16'hA5A5, 6, 0, 0, 0, 0, 1, 0, "postrst");

        run(16'hA5A5, 2, 0, 2, 0, 0, 0, 0, "allbad");
        run(16'h5A5A, 2, 0, 2, 0, 1, 0, 0, "sat");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_test_sequencer.md
Name: sdram_test_sequencer

Overview:
- Avalon-MM master that drives the SDRAM controller's slave port on the DE10-Lite SDRAM path.
- On a start pulse it writes a seeded, address-derived pattern across a word range, then reads the range back with pipelined reads and compares every word.
- Reports busy/done/pass status, an error count and the first failing address; these feed LED/PIO status in the system.

Parameters:
- ADDR_W, 25, word-address width; legal range 17..32.
- DATA_W, 16, SDRAM data width; fixed at 16, byteenable is 2 bits.
- LAST_ADDR, 2**25-1, final word address tested; the range is 0..LAST_ADDR inclusive.
- MAX_PEND, 8, maximum outstanding reads; power of 2, range 2..64.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins a run; ignored while busy.
- seed  in  16  pattern seed, sampled on an accepted start.
- avm_address  out  ADDR_W  word address.
- avm_read  out  1  read command.
- avm_write  out  1  write command.
- avm_writedata  out  16  write data.
- avm_byteenable  out  2  always 2'b11.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  16  read data.
- avm_readdatavalid  in  1  read data valid, returned in order.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start.
- pass  out  1  done with err_count==0.
- err_count  out  16  mismatch count, saturates at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.

Behaviour:
- Reset values:
  - all outputs 0; avm_byteenable=2'b11.
  - state IDLE.
  - counters 0, seed register 0.
- Pattern: pat(a) = a[15:0] ^ zero-extended a[ADDR_W-1:16] ^ seed_q.
- Avalon rules:
  - A command is accepted on the cycle it is asserted with waitrequest=0.
  - While waitrequest=1, address, data and command are held stable.
  - read and write are never asserted together.
- States:
  - IDLE: on start, latch seed, clear err_count, first_err_addr, done and pass, set busy, set waddr=0, go to WRITE.
  - DONE: behaves as IDLE; done and pass stay held until the next start.
  - WRITE: avm_write=1, address=waddr, data=pat(waddr). On accept, waddr++. On accept at waddr==LAST_ADDR, go to READ with raddr=0, caddr=0.
  - READ: assert avm_read whenever pend < MAX_PEND. On accept, raddr++. On accept at raddr==LAST_ADDR, go to DRAIN.
  - DRAIN: no commands. When pend==0, go to DONE and set done=1, busy=0, pass=(err_count==0).
- Outstanding-read counter (pend):
  - +1 on a read accept, -1 on readdatavalid.
  - On the same cycle it is unchanged.
  - Width is clog2(MAX_PEND)+1.
  - Reads are never issued with pend==MAX_PEND.
- Checking:
  - On each readdatavalid in READ or DRAIN, compare readdata against pat(caddr), then caddr++.
  - On mismatch, err_count++ (saturating). If this is the first error of the run, first_err_addr=caddr.
  - readdatavalid in IDLE, WRITE or DONE is ignored.
- Latency:
  - The first write is asserted the cycle after start.
  - READ begins the cycle after the last write is accepted.
  - done rises the cycle after the final readdatavalid, or in the same-cycle condition pend==0 in DRAIN.
- Boundaries:
  - LAST_ADDR=0 gives one write and one read.
  - The address counters never wrap: LAST_ADDR ≤ 2**ADDR_W-1 is a checked precondition, enforced by a synthesis-time assertion.
  - A start in WRITE, READ or DRAIN is ignored.
  - Reset mid-run returns immediately to IDLE with commands deasserted. The interconnect shares the same reset, so the abandoned transaction is acceptable.

Decomposition:
- Package sdram_test_pkg:
  - state enum (IDLE, WRITE, READ, DRAIN, DONE).
  - pattern function pat().
  - constant BE_ALL=2'b11.
- One sub-module, sdram_test_checker:
  - owns caddr, comparison, err_count saturation and first_err_addr capture.
  - interface: rdv, rdata, clear, seed.
- The top module keeps the FSM, the address counters and pend.

Test Plan (LAST_ADDR=15, MAX_PEND=4, seed=16'hA5A5, model slave with zero-latency memory unless stated):
- Clean run, waitrequest=0, 2-cycle read latency → 16 writes with data 16'hA5A5^a, 16 reads, done=1, pass=1, err_count=0, never more than 4 reads pending.
- Slave inverts bit 0 at address 5 → err_count=1, first_err_addr=5, pass=0, done=1.
- Random waitrequest at 50% plus read latency of 6 cycles → command signals held stable under stall, pend peaks at 4, pass=1.
- Readdatavalid and a read accept in the same cycle with pend=3 → pend stays 3. Start asserted mid-run → ignored, seed unchanged.
- Reset asserted during READ with pend=2 → next cycle all outputs 0 and state IDLE. A following start runs a clean pass.
- Slave corrupts every word, and a second scenario forces err_count near 16'hFFFF → first_err_addr=0, err_count=16 in the first case, and err_count saturates without wrap in the second.
